// File: rtl/gb_lcd_capture.sv
// Game Boy LCD bus capture: syncs the async LCD pins into clk and writes pixels into a 160x144 framebuffer.
// Optional macro GB_CAPTURE_DOUBLE_BUFFER_EN adds fb_bank and a bank-select MSB on fb_addr.
module gb_lcd_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gb_clk,
  input  logic              gb_hsync,
  input  logic              gb_vsync,
  input  logic [1:0]        gb_data,
  output logic              fb_we,
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  output logic [ADDR_W:0]   fb_addr,
  output logic              fb_bank,
`else
  output logic [ADDR_W-1:0] fb_addr,
`endif
  output logic [1:0]        fb_data,
  output logic              frame_done,
  output logic              locked,
  output logic              overrun
);

  localparam logic [7:0]        H_LIM  = 8'(H_PIXELS);
  localparam logic [7:0]        V_LIM  = 8'(V_LINES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        ctl_s1_q, ctl_s1_d, ctl_s2_q, ctl_s2_d, ctl_hist_q, ctl_hist_d;
  logic [1:0]        dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic              pix_evt_q, pix_evt_d, line_evt_q, line_evt_d, frame_evt_q, frame_evt_d;
  logic [1:0]        pix_dat_q, pix_dat_d;
  logic [7:0]        x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d, line_base_q, line_base_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              fb_we_q, fb_we_d;
  logic [1:0]        fb_data_q, fb_data_d;
  logic              frame_done_q, frame_done_d;
  logic              locked_q, locked_d;
  logic              overrun_q, overrun_d;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  logic              fb_bank_q, fb_bank_d, wr_bank_q, wr_bank_d;
`endif

  // Synchronisers, edge strobes (registered so data and events stay aligned) and capture state machine.
  always_comb begin
    ctl_s1_d    = {gb_vsync, gb_hsync, gb_clk};
    ctl_s2_d    = ctl_s1_q;
    ctl_hist_d  = ctl_s2_q;
    dat_s1_d    = gb_data;
    dat_s2_d    = dat_s1_q;
    pix_evt_d   = ctl_hist_q[0] & ~ctl_s2_q[0];
    line_evt_d  = ~ctl_hist_q[1] & ctl_s2_q[1];
    frame_evt_d = ~ctl_hist_q[2] & ctl_s2_q[2];
    pix_dat_d   = dat_s2_q;

    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    line_base_d  = line_base_q;
    wr_addr_d    = wr_addr_q;
    fb_we_d      = 1'b0;
    fb_data_d    = fb_data_q;
    frame_done_d = 1'b0;
    locked_d     = locked_q;
    overrun_d    = overrun_q;

    case (state_q)
      WAIT_FRAME: begin
        if (frame_evt_q) begin
          state_d     = ACTIVE;
          x_d         = 8'd0;
          y_d         = 8'd0;
          addr_d      = '0;
          line_base_d = '0;
          locked_d    = 1'b1;
        end else begin
          state_d = WAIT_FRAME;
        end
      end
      ACTIVE: begin
        // Coordinate updates land first so a coincident pixel writes at the new line/frame origin.
        if (frame_evt_q) begin
          frame_done_d = (x_q != 8'd0) || (y_q != 8'd0);
          x_d          = 8'd0;
          y_d          = 8'd0;
          addr_d       = '0;
          line_base_d  = '0;
        end else if (line_evt_q) begin
          x_d         = 8'd0;
          y_d         = (y_q < V_LIM) ? (y_q + 8'd1) : y_q;
          line_base_d = line_base_q + H_STEP;
          addr_d      = line_base_q + H_STEP;
        end else begin
          state_d = ACTIVE;
        end

        if (pix_evt_q) begin
          if ((x_d < H_LIM) && (y_d < V_LIM)) begin
            fb_we_d   = 1'b1;
            wr_addr_d = addr_d;
            fb_data_d = pix_dat_q;
            x_d       = x_d + 8'd1;
            addr_d    = addr_d + A_ONE;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          fb_we_d = 1'b0;
        end
      end
      default: begin
        state_d = WAIT_FRAME;
      end
    endcase

`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
    fb_bank_d = fb_bank_q ^ frame_done_d;
    wr_bank_d = fb_we_d ? ~fb_bank_d : wr_bank_q;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_FRAME;
      ctl_s1_q     <= 3'b000;
      ctl_s2_q     <= 3'b000;
      ctl_hist_q   <= 3'b000;
      dat_s1_q     <= 2'b00;
      dat_s2_q     <= 2'b00;
      pix_evt_q    <= 1'b0;
      line_evt_q   <= 1'b0;
      frame_evt_q  <= 1'b0;
      pix_dat_q    <= 2'b00;
      x_q          <= 8'd0;
      y_q          <= 8'd0;
      addr_q       <= '0;
      line_base_q  <= '0;
      wr_addr_q    <= '0;
      fb_we_q      <= 1'b0;
      fb_data_q    <= 2'b00;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
      fb_bank_q    <= 1'b0;
      wr_bank_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ctl_s1_q     <= ctl_s1_d;
      ctl_s2_q     <= ctl_s2_d;
      ctl_hist_q   <= ctl_hist_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      pix_evt_q    <= pix_evt_d;
      line_evt_q   <= line_evt_d;
      frame_evt_q  <= frame_evt_d;
      pix_dat_q    <= pix_dat_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      line_base_q  <= line_base_d;
      wr_addr_q    <= wr_addr_d;
      fb_we_q      <= fb_we_d;
      fb_data_q    <= fb_data_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
      overrun_q    <= overrun_d;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
      fb_bank_q    <= fb_bank_d;
      wr_bank_q    <= wr_bank_d;
`endif
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_data    = fb_data_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign overrun    = overrun_q;
`ifdef GB_CAPTURE_DOUBLE_BUFFER_EN
  assign fb_addr    = {wr_bank_q, wr_addr_q};
  assign fb_bank    = fb_bank_q;
`else
  assign fb_addr    = wr_addr_q;
`endif

endmodule

// File: doc/gb_lcd_capture.md
Name: gb_lcd_capture

Overview:
- Receiver side of the video path: samples the Game Boy LCD output bus (pixel clock, line pulse, frame pulse, 2-bit data) in the 25 MHz system domain.
- Rebuilds pixel coordinates and writes each 2-bit pixel into the 160x144 framebuffer write port.
- Sits between the cartridge-slot/LCD pins and the framebuffer RAM that the VGA scan-out side reads.

Parameters:
- H_PIXELS, 160, active pixels per GB line
- V_LINES, 144, active lines per GB frame
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES

Ports:
- clk  input  1  system clock (25 MHz pixel clock domain)
- reset  input  1  synchronous, active-high reset
- gb_clk  input  1  GB LCD pixel clock (async); data valid on its falling edge
- gb_hsync  input  1  GB line latch pulse (async); rising edge = end of line
- gb_vsync  input  1  GB frame pulse (async); rising edge = start of frame
- gb_data  input  2  GB pixel data LD1:LD0 (async)
- fb_we  output  1  framebuffer write strobe, one clk wide
- fb_addr  output  ADDR_W  write address = y*H_PIXELS + x
- fb_data  output  2  pixel value
- frame_done  output  1  one-clk pulse when a frame completes
- locked  output  1  high once the first frame start has been seen
- overrun  output  1  sticky: pixel arrived outside the 160x144 window

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Input synchronisation:
  - gb_clk, gb_hsync and gb_vsync each pass through a 2-FF synchroniser plus a history register for edge detection.
  - gb_data passes through the same 2-FF depth, so it stays aligned with the gb_clk edge.
- Edge events, each a single-cycle internal strobe:
  - pix_evt: falling edge of synced gb_clk.
  - line_evt: rising edge of synced gb_hsync.
  - frame_evt: rising edge of synced gb_vsync.
- State machine:
  - WAIT_FRAME (reset state): ignores pix_evt and line_evt. On frame_evt: go to ACTIVE, x=0, y=0, addr=0, line_base=0.
  - ACTIVE:
    - frame_evt: if x or y is nonzero, pulse frame_done. Then x=0, y=0, addr=0, line_base=0.
    - line_evt (no frame_evt): x=0, y=y+1 (saturates at V_LINES), line_base=line_base+H_PIXELS, addr=line_base+H_PIXELS.
    - pix_evt with x<H_PIXELS and y<V_LINES: fb_we=1, fb_addr=addr, fb_data=synced data. Then x++ and addr++.
    - pix_evt otherwise: no write; overrun set to 1.
- Address arithmetic is incremental only (no multiplier). addr and line_base are ADDR_W bits. x is 8 bits, y is 8 bits.
- Simultaneous events:
  - frame_evt has priority over line_evt.
  - Coordinate updates from frame_evt or line_evt apply first. A pix_evt in the same cycle writes at the updated position (x=0 of the new line or frame).
- Output latency:
  - fb_we, fb_addr and fb_data are registered and valid one clk after the pix_evt cycle.
  - frame_done is registered the same way.
  - Total latency from a gb_clk pin falling edge to fb_we is 4 clk.
- Reset values:
  - Outputs: fb_we=0, fb_addr=0, fb_data=0, frame_done=0, locked=0, overrun=0.
  - Internal: state=WAIT_FRAME, x=0, y=0, addr=0, line_base=0, synchroniser and history registers all 0.
  - Reset mid-frame discards the current frame; capture resumes at the next frame_evt.
- locked: set on the first frame_evt; cleared only by reset.
- overrun: cleared only by reset.

Optional Feature:
- Macro: GB_CAPTURE_DOUBLE_BUFFER_EN.
- Defined:
  - Adds output port fb_bank (1 bit, reset 0), which toggles on every frame_done.
  - fb_addr widens to ADDR_W+1 bits. The MSB is the bank being written, i.e. the inverse of fb_bank. fb_bank names the completed bank that scan-out should read.
- Undefined: no fb_bank port; fb_addr is ADDR_W bits, single buffer.

Test Plan:
- Reset, then 5 pixel edges with no vsync -> fb_we never asserts; locked=0.
- vsync pulse, 160 pixels of data 2'b10, hsync, 160 pixels of 2'b01 -> 320 writes: addr 0..159 with data 2, then addr 160..319 with data 1. fb_we appears 4 clk after each gb_clk falling edge.
- Full frame of 144 lines x 160 pixels, then vsync -> last write at addr 23039; frame_done pulses once; overrun=0.
- 161 pixels on one line -> 160 writes; overrun=1 and stays 1 through the next frame.
- hsync and vsync rising in the same clk, mid-frame at y=50 -> y=0, x=0, frame_done pulse; the next pixel writes addr 0.
- With GB_CAPTURE_DOUBLE_BUFFER_EN: two full frames -> first frame writes with MSB=1, fb_bank goes 0->1->0, second frame writes with MSB=0.
